// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - instruction decode type shared by the control unit, its bus interface and the bench
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit <-> data path signal bundle
interface control_unit_if;
  import k_and_s_pkg::*;

  // decode and flag inputs towards the control unit
  decoded_instruction_type decoded_instruction;
  logic        zero_op;
  logic        neg_op;
  logic        unsigned_overflow;
  logic        signed_overflow;

  // data path controls from the control unit
  logic        branch;
  logic        pc_enable;
  logic        ir_enable;
  logic        addr_sel;
  logic        c_sel;
  logic [1:0]  operation;
  logic        write_reg_enable;
  logic        flags_reg_enable;
  logic        ram_write_enable;
  logic        halt;
  logic [15:0] instr_count;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_count
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_count
  );

endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer for the K&S processor
module control_unit
  import k_and_s_pkg::*;
(
  input logic            clk,
  input logic            rst,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    LOAD_ADDR,
    LOAD_WB,
    STORE,
    MOVE,
    ALU,
    BRANCH,
    HALT
  } state_t;

  state_t                  state;
  state_t                  next_state;
  decoded_instruction_type instr_q;
  logic [15:0]             count_q;
  logic                    branch_taken;
  logic                    unused_signed_overflow;

  // no branch condition tests signed overflow
  assign unused_signed_overflow = bus.signed_overflow;

  // next state; the instruction is looked at only while in DECODE
  always_comb begin
    next_state = state;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (bus.decoded_instruction)
          I_LOAD:                        next_state = LOAD_ADDR;
          I_STORE:                       next_state = STORE;
          I_MOVE:                        next_state = MOVE;
          I_ADD, I_SUB, I_AND, I_OR:     next_state = ALU;
          I_BRANCH, I_BZERO, I_BNZERO,
          I_BNEG, I_BNNEG, I_BOV, I_BNOV: next_state = BRANCH;
          I_HALT:                        next_state = HALT;
          default:                       next_state = FETCH;
        endcase
      end
      LOAD_ADDR: next_state = LOAD_WB;
      LOAD_WB, STORE, MOVE, ALU, BRANCH: next_state = FETCH;
      HALT:      next_state = HALT;
      default:   next_state = FETCH;
    endcase
  end

  // state, latched instruction and completed-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      instr_q <= I_NOP;
      count_q <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        instr_q <= bus.decoded_instruction;
      end
      // an instruction completes whenever we re-enter FETCH; HALT never does
      if ((next_state == FETCH) && (state != FETCH)) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // branch condition, evaluated on the flags present during the BRANCH cycle
  always_comb begin
    branch_taken = 1'b0;
    case (instr_q)
      I_BRANCH: branch_taken = 1'b1;
      I_BZERO:  branch_taken = bus.zero_op;
      I_BNZERO: branch_taken = !bus.zero_op;
      I_BNEG:   branch_taken = bus.neg_op;
      I_BNNEG:  branch_taken = !bus.neg_op;
      I_BOV:    branch_taken = bus.unsigned_overflow;
      I_BNOV:   branch_taken = !bus.unsigned_overflow;
      default:  branch_taken = 1'b0;
    endcase
  end

  // control outputs decoded from the state; reset holds every output low
  always_comb begin
    bus.branch           = 1'b0;
    bus.pc_enable        = 1'b0;
    bus.ir_enable        = 1'b0;
    bus.addr_sel         = 1'b0;
    bus.c_sel            = 1'b0;
    bus.operation        = 2'b00;
    bus.write_reg_enable = 1'b0;
    bus.flags_reg_enable = 1'b0;
    bus.ram_write_enable = 1'b0;
    bus.halt             = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:  bus.ir_enable = 1'b1;
        DECODE: bus.pc_enable = 1'b1;
        LOAD_ADDR: bus.addr_sel = 1'b1;
        LOAD_WB: begin
          bus.addr_sel         = 1'b1;
          bus.c_sel            = 1'b1;
          bus.write_reg_enable = 1'b1;
        end
        STORE: begin
          bus.addr_sel         = 1'b1;
          bus.ram_write_enable = 1'b1;
        end
        MOVE: begin
          bus.operation        = 2'b10;
          bus.write_reg_enable = 1'b1;
        end
        ALU: begin
          bus.write_reg_enable = 1'b1;
          bus.flags_reg_enable = 1'b1;
          case (instr_q)
            I_AND:   bus.operation = 2'b01;
            I_OR:    bus.operation = 2'b10;
            I_SUB:   bus.operation = 2'b11;
            default: bus.operation = 2'b00;
          endcase
        end
        BRANCH: begin
          bus.addr_sel  = 1'b1;
          bus.branch    = branch_taken;
          bus.pc_enable = branch_taken;
        end
        HALT:    bus.halt = 1'b1;
        default: bus.ir_enable = 1'b0;
      endcase
    end
  end

  assign bus.instr_count = rst ? 16'h0000 : count_q;

endmodule
